button_event_fsm: RTL and testbench

- Sits directly downstream of the switch debouncer.
- Consumes the clean, active-high debounced level (switch_state) and classifies each interaction as one of three events: short press, long press or double press.
- Each event is a single-cycle pulse that drives lab control logic, e.g. mode select and counter step/clear.
- Single clock domain. The input is already synchronous to clk, so no synchronisers are needed.

---
 rtl/button_pkg.sv | 18 +
 rtl/edge_detect.sv | 22 ++
 rtl/button_event_fsm.sv | 111 +++++++++++
 tb/tb_button_event_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and 50 MHz timing defaults
// for the button event classifier.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND
  } btn_state_t;

  // 0.25 s hold at 50 MHz
  localparam int unsigned LONG_CYCLES_DEF = 12_500_000;
  // 0.15 s double-press window at 50 MHz
  localparam int unsigned GAP_CYCLES_DEF  = 7_500_000;

endpackage

// File: rtl/edge_detect.sv
// Registered-level edge detector for a
// synchronous switch or key input.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic level_q;

  // remember last cycle's level
  always_ff @(posedge clk) begin
    if (!reset_n) level_q <= 1'b0;
    else          level_q <= d;
  end

  assign rise = d & ~level_q;
  assign fall = ~d & level_q;

endmodule

// File: rtl/button_event_fsm.sv
// Classifies debounced button activity into
// short, long and double press pulses.
module button_event_fsm
  import button_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic switch_state,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);

  logic rise;
  logic fall;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;

  edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (switch_state),
    .rise    (rise),
    .fall    (fall)
  );

  // next state, interval count and event pulses
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) state_d = IDLE;
      end
      WAIT_GAP: begin
        if (rise) begin
          state_d = SECOND;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SECOND: begin
        if (fall) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and registered pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: timestamp model
// checked every cycle plus pinned event times.
module tb_button_event_fsm;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  localparam int P_NONE  = 0;
  localparam int P_FIRST = 1;
  localparam int P_HELD  = 2;
  localparam int P_GAP   = 3;
  localparam int P_SEC   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic switch_state = 1'b0;
  logic short_press, long_press;
  logic double_press, busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int ph = P_NONE;
  bit prev = 1'b0;
  int t_press = 0;
  int t_rel = 0;
  bit e_s, e_l, e_d, e_b;

  int n_s = 0, n_l = 0, n_d = 0;
  int t_s = -1, t_l = -1, t_d = -1;

  button_event_fsm #(
    .CNT_W       (8),
    .LONG_CYCLES (LONG),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .switch_state (switch_state),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d",
                  nm, cyc, act, exp);
  endtask

  // Model: classify by timestamps of edges.
  // Events raised at edge n are visible after it.
  always @(posedge clk) begin
    bit r, f;
    cyc++;
    e_s = 0;
    e_l = 0;
    e_d = 0;
    if (!reset_n) begin
      ph = P_NONE;
      prev = 0;
      chk_en = 1;
    end else begin
      r = switch_state && !prev;
      f = !switch_state && prev;
      prev = switch_state;
      case (ph)
        P_NONE:
          if (r) begin ph = P_FIRST; t_press = cyc; end
        P_FIRST:
          if (f) begin ph = P_GAP; t_rel = cyc; end
          else if (cyc - t_press == LONG) begin
            ph = P_HELD;
            e_l = 1;
          end
        P_HELD:
          if (f) ph = P_NONE;
        P_GAP:
          if (r) ph = P_SEC;
          else if (cyc - t_rel == GAP) begin
            ph = P_NONE;
            e_s = 1;
          end
        P_SEC:
          if (f) begin ph = P_NONE; e_d = 1; end
        default: ph = P_NONE;
      endcase
    end
    e_b = (ph != P_NONE);
  end

  // compare every cycle, log pulse times
  always @(negedge clk) begin
    if (chk_en) begin
      check("short_press", int'(short_press), int'(e_s));
      check("long_press", int'(long_press), int'(e_l));
      check("double_press", int'(double_press), int'(e_d));
      check("busy", int'(busy), int'(e_b));
      if (short_press) begin n_s++; t_s = cyc; end
      if (long_press) begin n_l++; t_l = cyc; end
      if (double_press) begin n_d++; t_d = cyc; end
    end
  end

  // hold a level for n sampling edges
  task automatic drive(input bit v, input int n);
    switch_state = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int r, f, s0, l0, d0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_pulses",
          int'(short_press | long_press | double_press), 0);
    reset_n = 1'b1;
    drive(0, 3);

    // short press
    s0 = n_s; l0 = n_l; d0 = n_d;
    r = cyc + 1;
    drive(1, 5);
    f = cyc + 1;
    drive(0, 15);
    check("short_time", t_s, f + 10);
    check("short_cnt", n_s - s0, 1);
    check("short_other", (n_l - l0) + (n_d - d0), 0);

    // long press
    s0 = n_s; l0 = n_l; d0 = n_d;
    r = cyc + 1;
    drive(1, 40);
    drive(0, 5);
    check("long_time", t_l, r + 20);
    check("long_cnt", n_l - l0, 1);
    check("long_other", (n_s - s0) + (n_d - d0), 0);

    // double press
    s0 = n_s; d0 = n_d;
    drive(1, 4);
    drive(0, 3);
    drive(1, 4);
    f = cyc + 1;
    drive(0, 15);
    check("double_time", t_d, f);
    check("double_cnt", n_d - d0, 1);
    check("double_noshort", n_s - s0, 0);

    // gap expires before the next press
    s0 = n_s; d0 = n_d;
    drive(1, 4);
    f = cyc + 1;
    drive(0, 11);
    drive(1, 4);
    r = cyc + 1;
    drive(0, 15);
    check("gap_short_time", t_s, r + 10);
    check("gap_short_cnt", n_s - s0, 2);
    check("gap_no_double", n_d - d0, 0);

    // rise on the timeout edge wins
    s0 = n_s; d0 = n_d;
    drive(1, 4);
    drive(0, 10);
    drive(1, 4);
    f = cyc + 1;
    drive(0, 15);
    check("gap_tie_time", t_d, f);
    check("gap_tie_cnt", n_d - d0, 1);
    check("gap_tie_short", n_s - s0, 0);

    // well inside the gap
    s0 = n_s; d0 = n_d;
    drive(1, 4);
    drive(0, 9);
    drive(1, 4);
    f = cyc + 1;
    drive(0, 15);
    check("gap9_time", t_d, f);
    check("gap9_short", n_s - s0, 0);

    // reset mid-press with level held
    s0 = n_s; l0 = n_l; d0 = n_d;
    drive(1, 10);
    reset_n = 1'b0;
    drive(1, 2);
    check("rst_quiet", (n_s - s0) + (n_l - l0) + (n_d - d0), 0);
    reset_n = 1'b1;
    r = cyc + 1;
    drive(1, 25);
    drive(0, 5);
    check("rst_long_time", t_l, r + 20);
    check("rst_long_cnt", n_l - l0, 1);

    // fall on the long-boundary edge
    s0 = n_s; l0 = n_l;
    drive(1, 20);
    f = cyc + 1;
    drive(0, 15);
    check("tie_short_time", t_s, f + 10);
    check("tie_no_long", n_l - l0, 0);
    check("tie_short_cnt", n_s - s0, 1);

    drive(0, 2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
